// File: rtl/halve_tokens_if.sv
// Token stream bundle for halve_tokens: doubled input stream in, decoded stream
// and sticky error flags out.
interface halve_tokens_if;
  logic b;
  logic a;
  logic overflow;
  logic odd_error;

  modport master (output b, input  a, overflow, odd_error);
  modport slave  (input  b, output a, overflow, odd_error);
endinterface

// File: rtl/halve_tokens.sv
// Serial token halver: measures each run of doubled '1's and re-emits half as many tokens.
// Optional parity checking of run lengths is built when HALVE_TOKENS_ODD_CHECK_EN is defined.
module halve_tokens #(
  parameter int MAX_RUN = 400
) (
  input  logic           clk,
  input  logic           rst,
  halve_tokens_if.slave  tok
);

  localparam int RW = $clog2(MAX_RUN + 2);
  localparam int PW = $clog2(MAX_RUN + 1);

  localparam logic [RW-1:0] RUN_SAT  = RW'(MAX_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_RUN);
  localparam logic [PW:0]   PEND_MAX = (PW+1)'(MAX_RUN);

  logic [RW-1:0] run_cnt;
  logic [PW-1:0] pending;
  logic          ovf_q;

  logic          run_end;
  logic          dec;
  logic          clamp;
  logic [PW:0]   add;
  logic [PW:0]   sum;

  // One extra bit on the sum so pending+add never wraps before the clamp test.
  always_comb begin
    run_end = !tok.b && (run_cnt != '0);
    add     = '0;
    if (run_end && (run_cnt != RUN_SAT))
      add = (PW+1)'(run_cnt >> 1);
    dec     = (pending != '0);
    sum     = {1'b0, pending} + add - (PW+1)'(dec);
    clamp   = (sum > PEND_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
      pending <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (tok.b) begin
        if (run_cnt != RUN_SAT) run_cnt <= run_cnt + RW'(1);
        if (run_cnt == RUN_MAX) ovf_q <= 1'b1;
      end else begin
        run_cnt <= '0;
      end
      pending <= clamp ? PW'(MAX_RUN) : sum[PW-1:0];
      if (clamp) ovf_q <= 1'b1;
    end
  end

  assign tok.a        = (pending != '0);
  assign tok.overflow = ovf_q;

`ifdef HALVE_TOKENS_ODD_CHECK_EN
  logic odd_q;

  // A saturated run is odd by construction; it is reported as overflow, not parity.
  always_ff @(posedge clk) begin
    if (rst)
      odd_q <= 1'b0;
    else if (run_end && run_cnt[0] && (run_cnt != RUN_SAT))
      odd_q <= 1'b1;
  end

  assign tok.odd_error = odd_q;
`else
  assign tok.odd_error = 1'b0;
`endif

endmodule

// File: tb/tb_halve_tokens.sv
// Bench for halve_tokens: directed scenarios plus random runs, checked against a
// time-interval model of when decoded tokens should appear.
module tb_halve_tokens;
  localparam int MAX_RUN = 400;
`ifdef HALVE_TOKENS_ODD_CHECK_EN
  localparam bit ODD_EN = 1'b1;
`else
  localparam bit ODD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  halve_tokens_if ifc ();

  halve_tokens #(.MAX_RUN(MAX_RUN)) dut (
    .clk (clk),
    .rst (rst),
    .tok (ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: tokens occupy the cycle interval [cur_start, busy_end); each run end
  // appends L/2 cycles to it, starting no earlier than the cycle after the run.
  int cyc       = 0;
  int run_len   = 0;
  int cur_start = 0;
  int busy_end  = 0;
  int tok_cnt   = 0;
  bit exp_ovf   = 1'b0;
  bit exp_odd   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic bv);
    int n;
    ifc.b = bv;
    @(posedge clk);
    #1;
    if (rst) begin
      run_len = 0; cur_start = 0; busy_end = 0; exp_ovf = 1'b0; exp_odd = 1'b0;
    end else if (bv) begin
      if (run_len == MAX_RUN) exp_ovf = 1'b1;
      if (run_len <= MAX_RUN) run_len++;
    end else if (run_len > 0) begin
      n = (run_len > MAX_RUN) ? 0 : run_len / 2;
      if (ODD_EN && run_len <= MAX_RUN && (run_len % 2) == 1) exp_odd = 1'b1;
      if (busy_end <= cyc + 1) begin
        cur_start = cyc + 1;
        busy_end  = cyc + 1 + n;
      end else begin
        busy_end  = busy_end + n;
      end
      run_len = 0;
    end
    cyc++;
    tok_cnt += int'(ifc.a);
    chk("a",         {31'b0, ifc.a},         32'((cyc >= cur_start) && (cyc < busy_end)));
    chk("overflow",  {31'b0, ifc.overflow},  32'(exp_ovf));
    chk("odd_error", {31'b0, ifc.odd_error}, 32'(exp_odd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic ones(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    string s;
    int    exp_tok;
    int    len;

    ifc.b = 1'b0;

    // Reset held two cycles with b=1, then released with b=0
    rst = 1'b1;
    ones(2);
    chk("rst_a",   {31'b0, ifc.a},         32'd0);
    chk("rst_ovf", {31'b0, ifc.overflow},  32'd0);
    chk("rst_odd", {31'b0, ifc.odd_error}, 32'd0);
    rst = 1'b0;
    step(1'b0);
    chk("post_rst_a", {31'b0, ifc.a}, 32'd0);

    // Single pair: one token, one cycle after the run ends
    tok_cnt = 0;
    ones(2);
    step(1'b0);
    chk("pair_a_cycle3", {31'b0, ifc.a}, 32'd1);
    step(1'b0);
    chk("pair_a_cycle4", {31'b0, ifc.a}, 32'd0);
    idle(3);
    chk("pair_tokens", 32'(tok_cnt), 32'd1);

    // Doubler output stream: groups 1,1,2,3,3
    tok_cnt = 0;
    s = "11011011110111111001111110";
    for (int i = 0; i < s.len(); i++) step(s[i] == "1");
    idle(20);
    chk("dbl_tokens", 32'(tok_cnt), 32'd10);
    chk("dbl_ovf",    {31'b0, ifc.overflow},  32'd0);
    chk("dbl_odd",    {31'b0, ifc.odd_error}, 32'd0);

    // Odd run of three
    pulse_rst();
    tok_cnt = 0;
    ones(3);
    idle(21);
    chk("odd_tokens", 32'(tok_cnt), 32'd1);
    chk("odd_hold",   {31'b0, ifc.odd_error}, 32'(ODD_EN));

    // Run overflow: 401 ones, no tokens, sticky flag, then normal decoding resumes
    pulse_rst();
    tok_cnt = 0;
    ones(MAX_RUN);
    chk("ovf_before", {31'b0, ifc.overflow}, 32'd0);
    step(1'b1);
    chk("ovf_rise", {31'b0, ifc.overflow}, 32'd1);
    idle(5);
    chk("ovf_no_tokens", 32'(tok_cnt), 32'd0);
    ones(2);
    idle(4);
    chk("ovf_resume_tokens", 32'(tok_cnt), 32'd1);
    chk("ovf_sticky", {31'b0, ifc.overflow}, 32'd1);
    pulse_rst();
    chk("ovf_cleared", {31'b0, ifc.overflow}, 32'd0);

    // Back-to-back maximum legal runs
    tok_cnt = 0;
    ones(MAX_RUN);
    step(1'b0);
    ones(MAX_RUN);
    step(1'b0);
    idle(MAX_RUN / 2 + 10);
    chk("b2b_tokens", 32'(tok_cnt), 32'(MAX_RUN));
    chk("b2b_ovf",    {31'b0, ifc.overflow}, 32'd0);

    // Random runs with random gaps
    pulse_rst();
    tok_cnt = 0;
    exp_tok = 0;
    for (int r = 0; r < 60; r++) begin
      len = int'($urandom_range(1, 16));
      exp_tok += len / 2;
      ones(len);
      idle(int'($urandom_range(1, 4)));
    end
    idle(40);
    chk("rand_tokens", 32'(tok_cnt), 32'(exp_tok));
    chk("rand_ovf",    {31'b0, ifc.overflow}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
